// File: rtl/ram_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : ram_arbiter                                                |
// | Description : Three-requester round-robin arbiter in front of a single-  |
// |               port RAM. Each granted transaction walks IDLE -> ISSUE ->  |
// |               WAIT -> DONE. A stuck-busy RAM is aborted after TIMEOUT     |
// |               WAIT cycles and reported through err.                      |
// |               Optional feature macro: RAM_ARB_LOCK_EN (owner may hold    |
// |               the grant across transactions via lock[owner]).            |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module ram_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int BUS_WIDTH  = 8,
    parameter int TIMEOUT    = 15
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [2:0]              req,
    input  logic [2:0]              we,
    input  logic [3*BUS_WIDTH-1:0]  addr,
    input  logic [3*DATA_WIDTH-1:0] wdata,
    input  logic [2:0]              lock,
    output logic [2:0]              gnt,
    output logic [2:0]              done,
    output logic                    err,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [BUS_WIDTH-1:0]    ram_addr,
    output logic [DATA_WIDTH-1:0]   ram_wdata,
    output logic                    ram_rd_en,
    output logic                    ram_wr_en,
    input  logic [DATA_WIDTH-1:0]   ram_rd_data,
    input  logic                    ram_busy
);

    // Counter wide enough to hold TIMEOUT-1
    localparam int C_CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                r_state;
    logic [1:0]            r_owner;
    logic [1:0]            r_last;
    logic                  r_we;
    logic [C_CNT_W-1:0]    r_cnt;
    logic [2:0]            r_gnt;
    logic [2:0]            r_done;
    logic                  r_err;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [BUS_WIDTH-1:0]  r_ram_addr;
    logic [DATA_WIDTH-1:0] r_ram_wdata;
    logic                  r_ram_rd_en;
    logic                  r_ram_wr_en;

    logic [1:0]            w_sel;
    logic [2:0]            w_sel_oh;
    logic [2:0]            w_owner_oh;
    logic                  w_we;
    logic [BUS_WIDTH-1:0]  w_addr;
    logic [DATA_WIDTH-1:0] w_wdata;

`ifdef RAM_ARB_LOCK_EN
    logic                  r_lock_hold;
`else
    // lock is part of the port list but has no effect in this build
    logic                  w_unused_lock;
    assign w_unused_lock = ^lock;
`endif

    function automatic logic [2:0] f_onehot(input logic [1:0] i_idx);
        f_onehot = 3'(3'b001 << i_idx);
    endfunction

    // Round-robin pick starting after the last owner (optionally held by lock)
    always_comb begin
        w_sel = 2'd0;
        case (r_last)
            2'd0:    w_sel = req[1] ? 2'd1 : (req[2] ? 2'd2 : 2'd0);
            2'd1:    w_sel = req[2] ? 2'd2 : (req[0] ? 2'd0 : 2'd1);
            default: w_sel = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
        endcase
`ifdef RAM_ARB_LOCK_EN
        if (r_lock_hold && ((req & f_onehot(r_owner)) != 3'b000)) begin
            w_sel = r_owner;
        end
`endif
    end

    // Steer the selected requester's transaction fields
    always_comb begin
        w_we    = we[0];
        w_addr  = addr[0 +: BUS_WIDTH];
        w_wdata = wdata[0 +: DATA_WIDTH];
        case (w_sel)
            2'd1: begin
                w_we    = we[1];
                w_addr  = addr[BUS_WIDTH +: BUS_WIDTH];
                w_wdata = wdata[DATA_WIDTH +: DATA_WIDTH];
            end
            2'd2: begin
                w_we    = we[2];
                w_addr  = addr[2*BUS_WIDTH +: BUS_WIDTH];
                w_wdata = wdata[2*DATA_WIDTH +: DATA_WIDTH];
            end
            default: ;
        endcase
    end

    assign w_sel_oh   = f_onehot(w_sel);
    assign w_owner_oh = f_onehot(r_owner);

    // Transaction FSM; all outputs are registered here
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= S_IDLE;
            r_owner     <= 2'd0;
            r_last      <= 2'd2;
            r_we        <= 1'b0;
            r_cnt       <= '0;
            r_gnt       <= 3'b000;
            r_done      <= 3'b000;
            r_err       <= 1'b0;
            r_rdata     <= '0;
            r_ram_addr  <= '0;
            r_ram_wdata <= '0;
            r_ram_rd_en <= 1'b0;
            r_ram_wr_en <= 1'b0;
`ifdef RAM_ARB_LOCK_EN
            r_lock_hold <= 1'b0;
`endif
        end else begin
            // Pulsed outputs default low every cycle
            r_done      <= 3'b000;
            r_err       <= 1'b0;
            r_ram_rd_en <= 1'b0;
            r_ram_wr_en <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (|req) begin
                        r_owner     <= w_sel;
                        r_we        <= w_we;
                        r_ram_addr  <= w_addr;
                        r_ram_wdata <= w_wdata;
                        r_ram_rd_en <= ~w_we;
                        r_ram_wr_en <= w_we;
                        r_gnt       <= w_sel_oh;
                        r_state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_cnt   <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (!ram_busy) begin
                        if (!r_we) begin
                            r_rdata <= ram_rd_data;
                        end
                        r_done  <= w_owner_oh;
                        r_state <= S_DONE;
                    end else if (r_cnt == C_CNT_W'(TIMEOUT - 1)) begin
                        // RAM never answered: abort, rdata left untouched
                        r_done  <= w_owner_oh;
                        r_err   <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    r_gnt   <= 3'b000;
                    r_state <= S_IDLE;
`ifdef RAM_ARB_LOCK_EN
                    if ((lock & w_owner_oh) != 3'b000) begin
                        r_lock_hold <= 1'b1;
                    end else begin
                        r_lock_hold <= 1'b0;
                        r_last      <= r_owner;
                    end
`else
                    r_last <= r_owner;
`endif
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign gnt       = r_gnt;
    assign done      = r_done;
    assign err       = r_err;
    assign rdata     = r_rdata;
    assign ram_addr  = r_ram_addr;
    assign ram_wdata = r_ram_wdata;
    assign ram_rd_en = r_ram_rd_en;
    assign ram_wr_en = r_ram_wr_en;

endmodule
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_ram_arbiter                                             |
// | Description : Directed self-checking bench for ram_arbiter. Expected     |
// |               grant orders follow RAM_ARB_LOCK_EN when it is defined.    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_ram_arbiter;

    localparam int DW = 8;
    localparam int BW = 8;

    logic          clk;
    logic          rstn;
    logic [2:0]    req;
    logic [2:0]    we;
    logic [3*BW-1:0] addr;
    logic [3*DW-1:0] wdata;
    logic [2:0]    lock;
    logic [2:0]    gnt;
    logic [2:0]    done;
    logic          err;
    logic [DW-1:0] rdata;
    logic [BW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic          ram_rd_en;
    logic          ram_wr_en;
    logic [DW-1:0] ram_rd_data;
    logic          ram_busy;

    int n_checks  = 0;
    int n_fail    = 0;
    int n_overlap = 0;

    ram_arbiter #(.DATA_WIDTH(DW), .BUS_WIDTH(BW), .TIMEOUT(15)) u_dut (
        .clk        (clk),
        .rstn       (rstn),
        .req        (req),
        .we         (we),
        .addr       (addr),
        .wdata      (wdata),
        .lock       (lock),
        .gnt        (gnt),
        .done       (done),
        .err        (err),
        .rdata      (rdata),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_rd_en  (ram_rd_en),
        .ram_wr_en  (ram_wr_en),
        .ram_rd_data(ram_rd_data),
        .ram_busy   (ram_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        #2 rstn = 1'b0;
        step();
        step();
        #3 rstn = 1'b1;
    endtask

    // Advance until a done pulse appears, watching for overlapping grants
    task automatic wait_done(output logic [2:0] d);
        d = 3'b000;
        for (int n = 0; n < 25; n++) begin
            step();
            if (!$onehot0(gnt)) n_overlap++;
            if (done != 3'b000) begin
                d = done;
                break;
            end
        end
        check("done_seen", 32'(d != 3'b000), 32'd1);
    endtask

    logic [2:0] d;
    logic [2:0] e;
    logic [2:0] exp_lock [4];

    initial begin
        rstn = 1'b0; req = '0; we = '0; addr = '0; wdata = '0; lock = '0;
        ram_rd_data = '0; ram_busy = 1'b0;

        // ---- Reset values
        step();
        check("rst_gnt",   32'(gnt), 0);
        check("rst_done",  32'(done), 0);
        check("rst_err",   32'(err), 0);
        check("rst_rden",  32'(ram_rd_en), 0);
        check("rst_wren",  32'(ram_wr_en), 0);
        check("rst_addr",  32'(ram_addr), 0);
        check("rst_rdata", 32'(rdata), 0);
        #3 rstn = 1'b1;
        step();

        // ---- Single read, latency check
        req = 3'b001; we = 3'b000; addr[0 +: BW] = 8'h10;
        ram_rd_data = 8'hA5; ram_busy = 1'b0;
        step();
        check("rd_en_n1",  32'(ram_rd_en), 1);
        check("rd_wren",   32'(ram_wr_en), 0);
        check("rd_gnt",    32'(gnt), 32'b001);
        check("rd_addr",   32'(ram_addr), 32'h10);
        req = 3'b000;                 // drop mid-transaction, must be ignored
        step();
        check("rd_en_n2",  32'(ram_rd_en), 0);
        check("rd_done_n2", 32'(done), 0);
        step();
        check("rd_done_n3", 32'(done), 32'b001);
        check("rd_rdata",  32'(rdata), 32'hA5);
        check("rd_err",    32'(err), 0);
        step();
        check("rd_idle_gnt",  32'(gnt), 0);
        check("rd_idle_done", 32'(done), 0);

        // ---- Debug write with busy held 5 WAIT cycles
        req = 3'b100; we = 3'b100; addr[2*BW +: BW] = 8'h20; wdata[2*DW +: DW] = 8'h3C;
        ram_busy = 1'b1; ram_rd_data = 8'hFF;
        step();
        check("wr_en",     32'(ram_wr_en), 1);
        check("wr_rden",   32'(ram_rd_en), 0);
        check("wr_gnt",    32'(gnt), 32'b100);
        check("wr_addr",   32'(ram_addr), 32'h20);
        check("wr_wdata",  32'(ram_wdata), 32'h3C);
        req = 3'b000; addr[2*BW +: BW] = 8'h77; wdata[2*DW +: DW] = 8'h11;
        step();
        check("wr_en_off", 32'(ram_wr_en), 0);
        for (int i = 0; i < 4; i++) begin
            step();
            check("wr_hold_addr",  32'(ram_addr), 32'h20);
            check("wr_hold_wdata", 32'(ram_wdata), 32'h3C);
            check("wr_wait_done",  32'(done), 0);
        end
        step();
        ram_busy = 1'b0;
        check("wr_wait6_done", 32'(done), 0);
        step();
        check("wr_done",   32'(done), 32'b100);
        check("wr_err",    32'(err), 0);
        check("wr_rdata",  32'(rdata), 32'hA5);
        check("wr_gnt_d",  32'(gnt), 32'b100);
        step();
        check("wr_idle_done", 32'(done), 0);
        we = 3'b000;

        // ---- Timeout on stuck busy, then next requester served
        req = 3'b011; ram_busy = 1'b1; ram_rd_data = 8'h5A;
        addr[0 +: BW] = 8'h01; addr[BW +: BW] = 8'h02;
        step();
        check("to_gnt",    32'(gnt), 32'b001);
        req = 3'b010;
        for (int i = 0; i < 15; i++) step();
        check("to_w15_done", 32'(done), 0);
        step();
        check("to_done",   32'(done), 32'b001);
        check("to_err",    32'(err), 1);
        check("to_rdata",  32'(rdata), 32'hA5);
        ram_busy = 1'b0; ram_rd_data = 8'h66;
        step();
        check("to_idle_err", 32'(err), 0);
        check("to_idle_gnt", 32'(gnt), 0);
        step();
        check("to_next_gnt", 32'(gnt), 32'b010);
        check("to_next_addr", 32'(ram_addr), 32'h02);
        req = 3'b000;
        step();
        step();
        check("to_next_done", 32'(done), 32'b010);
        check("to_next_rdata", 32'(rdata), 32'h66);
        step();

        // ---- Round robin with all three requesting
        do_reset();
        req = 3'b111; we = 3'b000; ram_busy = 1'b0; ram_rd_data = 8'hC3;
        n_overlap = 0;
        for (int i = 0; i < 6; i++) begin
            wait_done(d);
            e = 3'(3'b001 << (i % 3));
            check("rr_order", 32'(d), 32'(e));
        end
        check("rr_gnt_onehot", 32'(n_overlap), 0);
        req = 3'b000;
        step();
        step();

        // ---- Asynchronous reset during WAIT
        req = 3'b001; ram_busy = 1'b1;
        step();
        step();
        check("ar_pre_gnt", 32'(gnt), 32'b001);
        #2 rstn = 1'b0;
        #1;
        check("ar_gnt",   32'(gnt), 0);
        check("ar_done",  32'(done), 0);
        check("ar_err",   32'(err), 0);
        check("ar_rden",  32'(ram_rd_en | ram_wr_en), 0);
        check("ar_addr",  32'(ram_addr), 0);
        check("ar_wdata", 32'(ram_wdata), 0);
        check("ar_rdata", 32'(rdata), 0);
        req = 3'b110; ram_busy = 1'b0;
        #2 rstn = 1'b1;
        step();
        check("ar_first_gnt", 32'(gnt), 32'b010);
        req = 3'b000;
        step();
        step();
        check("ar_first_done", 32'(done), 32'b010);
        step();

        // ---- Lock behaviour
        do_reset();
        exp_lock[0] = 3'b001;
`ifdef RAM_ARB_LOCK_EN
        exp_lock[1] = 3'b001;
        exp_lock[2] = 3'b001;
`else
        exp_lock[1] = 3'b010;
        exp_lock[2] = 3'b001;
`endif
        exp_lock[3] = 3'b010;
        req = 3'b011; lock = 3'b001; ram_busy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wait_done(d);
            check("lock_order", 32'(d), 32'(exp_lock[i]));
            if (i == 1) begin
                step();
                lock = 3'b000;
            end
        end
        req = 3'b000;
        step();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
